// File: rtl/frame_pixel_source.sv
// Test-pattern pixel source stepped by a VGA reader: solid, ramp, checkerboard or line buffer.
// Define FRAME_PIXEL_SOURCE_LINEBUF_EN to build the 16x4 line buffer and its write port.
module frame_pixel_source #(
  parameter int unsigned H_PIXELS = 160,
  parameter int unsigned V_LINES  = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_reset_in,
  input  logic       frame_next_pixel_in,
  input  logic [1:0] pattern_sel,
  input  logic [3:0] solid_level,
  input  logic       wr_en,
  input  logic [3:0] wr_data,
  input  logic       wr_ptr_clr,
  output logic [3:0] frame_pixel_out,
  output logic [7:0] frame_count
);

  localparam int unsigned XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int unsigned YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [XW-1:0] XMax = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] YMax = YW'(V_LINES - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [7:0]    fc_q, fc_d;
  logic [1:0]    pat_q, pat_d;
  logic [3:0]    lvl_q, lvl_d;
  logic [3:0]    pix_q, pix_d;
  logic          adv_prev_q;
  logic          adv;
  logic          frame_start;
  logic [3:0]    x4, y4;
  logic [3:0]    lb_rd;

  always_comb begin
    adv         = frame_next_pixel_in & ~adv_prev_q;
    x_d         = x_q;
    y_d         = y_q;
    fc_d        = fc_q;
    frame_start = 1'b0;
    if (frame_reset_in) begin
      // Restart wins; a coincident advance edge is dropped.
      x_d         = '0;
      y_d         = '0;
      frame_start = 1'b1;
    end else if (adv) begin
      if (x_q == XMax) begin
        x_d = '0;
        if (y_q == YMax) begin
          y_d         = '0;
          fc_d        = fc_q + 8'd1;
          frame_start = 1'b1;
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end
    pat_d = frame_start ? pattern_sel : pat_q;
    lvl_d = frame_start ? solid_level : lvl_q;
  end

  assign x4 = 4'(x_d);
  assign y4 = 4'(y_d);

`ifdef FRAME_PIXEL_SOURCE_LINEBUF_EN
  logic [3:0] linebuf [16];
  logic [3:0] wr_ptr_q;

  // Buffer contents survive reset; only the pointer is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
    end else if (wr_ptr_clr) begin
      wr_ptr_q <= '0;
    end else if (wr_en) begin
      linebuf[wr_ptr_q] <= wr_data;
      wr_ptr_q          <= wr_ptr_q + 4'd1;
    end
  end

  assign lb_rd = linebuf[x4];
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_data, wr_ptr_clr};
  assign lb_rd     = y4;
`endif

  always_comb begin
    pix_d = 4'h0;
    unique case (pat_d)
      2'd0: pix_d = lvl_d;
      2'd1: pix_d = x4;
      2'd2: pix_d = (x4[3] ^ y4[3]) ? 4'hF : 4'h0;
      2'd3: pix_d = lb_rd;
      default: pix_d = 4'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      fc_q       <= '0;
      pat_q      <= '0;
      lvl_q      <= '0;
      pix_q      <= '0;
      adv_prev_q <= 1'b0;
    end else begin
      adv_prev_q <= frame_next_pixel_in;
      x_q        <= x_d;
      y_q        <= y_d;
      fc_q       <= fc_d;
      pat_q      <= pat_d;
      lvl_q      <= lvl_d;
      if (frame_reset_in || adv) pix_q <= pix_d;
    end
  end

  assign frame_pixel_out = pix_q;
  assign frame_count     = fc_q;

endmodule

// File: tb/tb_frame_pixel_source.sv
// Scoreboard bench for frame_pixel_source: default-size instance plus a 4x2 instance for wraps.
module tb_frame_pixel_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       frame_reset_in, frame_next_pixel_in;
  logic [1:0] pattern_sel;
  logic [3:0] solid_level, wr_data;
  logic       wr_en, wr_ptr_clr;
  logic [3:0] frame_pixel_out;
  logic [7:0] frame_count;

  logic       s_frame_reset_in, s_frame_next_pixel_in;
  logic [1:0] s_pattern_sel;
  logic [3:0] s_solid_level;
  logic [3:0] s_frame_pixel_out;
  logic [7:0] s_frame_count;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q [$];
  logic [3:0] exp;

  frame_pixel_source u_dut (
    .clk                 (clk),
    .rst                 (rst),
    .frame_reset_in      (frame_reset_in),
    .frame_next_pixel_in (frame_next_pixel_in),
    .pattern_sel         (pattern_sel),
    .solid_level         (solid_level),
    .wr_en               (wr_en),
    .wr_data             (wr_data),
    .wr_ptr_clr          (wr_ptr_clr),
    .frame_pixel_out     (frame_pixel_out),
    .frame_count         (frame_count)
  );

  frame_pixel_source #(
    .H_PIXELS (4),
    .V_LINES  (2)
  ) u_small (
    .clk                 (clk),
    .rst                 (rst),
    .frame_reset_in      (s_frame_reset_in),
    .frame_next_pixel_in (s_frame_next_pixel_in),
    .pattern_sel         (s_pattern_sel),
    .solid_level         (s_solid_level),
    .wr_en               (1'b0),
    .wr_data             (4'h0),
    .wr_ptr_clr          (1'b0),
    .frame_pixel_out     (s_frame_pixel_out),
    .frame_count         (s_frame_count)
  );

  // Drive on negedge; on return the sampling edge has passed and outputs are settled.
  task automatic adv_pulse();
    @(negedge clk) frame_next_pixel_in = 1'b1;
    @(negedge clk) frame_next_pixel_in = 1'b0;
  endtask

  task automatic frame_pulse();
    @(negedge clk) frame_reset_in = 1'b1;
    @(negedge clk) frame_reset_in = 1'b0;
  endtask

  task automatic s_adv_pulse();
    @(negedge clk) s_frame_next_pixel_in = 1'b1;
    @(negedge clk) s_frame_next_pixel_in = 1'b0;
  endtask

  task automatic s_frame_pulse();
    @(negedge clk) s_frame_reset_in = 1'b1;
    @(negedge clk) s_frame_reset_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (frame_pixel_out !== 4'h0) begin
      errors++;
      $display("FAIL reset_pixel: got %h expected %h", frame_pixel_out, 4'h0);
    end
    checks++;
    if (frame_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected %0d", frame_count, 0);
    end
  endtask

  task automatic test_ramp();
    pattern_sel = 2'd1;
    exp_q.push_back(4'h0);
    frame_pulse();
    exp = exp_q.pop_front();
    checks++;
    if (frame_pixel_out !== exp) begin
      errors++;
      $display("FAIL ramp_start: got %h expected %h", frame_pixel_out, exp);
    end
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(4'(i));
      adv_pulse();
      exp = exp_q.pop_front();
      checks++;
      if (frame_pixel_out !== exp) begin
        errors++;
        $display("FAIL ramp_step%0d: got %h expected %h", i, frame_pixel_out, exp);
      end
    end
  endtask

  task automatic test_level_hold();
    exp_q.push_back(4'h0);
    frame_pulse();
    exp = exp_q.pop_front();
    checks++;
    if (frame_pixel_out !== exp) begin
      errors++;
      $display("FAIL hold_restart: got %h expected %h", frame_pixel_out, exp);
    end
    exp_q.push_back(4'h1);
    @(negedge clk) frame_next_pixel_in = 1'b1;
    repeat (5) @(negedge clk);
    frame_next_pixel_in = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (frame_pixel_out !== exp) begin
      errors++;
      $display("FAIL hold_single_advance: got %h expected %h", frame_pixel_out, exp);
    end
    exp_q.push_back(4'h2);
    adv_pulse();
    exp = exp_q.pop_front();
    checks++;
    if (frame_pixel_out !== exp) begin
      errors++;
      $display("FAIL hold_next_advance: got %h expected %h", frame_pixel_out, exp);
    end
  endtask

  task automatic test_reset_priority();
    frame_pulse();
    for (int i = 1; i <= 5; i++) adv_pulse();
    checks++;
    if (frame_pixel_out !== 4'h5) begin
      errors++;
      $display("FAIL prio_at_x5: got %h expected %h", frame_pixel_out, 4'h5);
    end
    exp_q.push_back(4'h0);
    @(negedge clk) begin
      frame_reset_in      = 1'b1;
      frame_next_pixel_in = 1'b1;
    end
    @(negedge clk) begin
      frame_reset_in      = 1'b0;
      frame_next_pixel_in = 1'b0;
    end
    exp = exp_q.pop_front();
    checks++;
    if (frame_pixel_out !== exp) begin
      errors++;
      $display("FAIL prio_pixel: got %h expected %h", frame_pixel_out, exp);
    end
    checks++;
    if (frame_count !== 8'd0) begin
      errors++;
      $display("FAIL prio_count: got %0d expected %0d", frame_count, 0);
    end
    exp_q.push_back(4'h1);
    adv_pulse();
    exp = exp_q.pop_front();
    checks++;
    if (frame_pixel_out !== exp) begin
      errors++;
      $display("FAIL prio_after: got %h expected %h", frame_pixel_out, exp);
    end
  endtask

  task automatic test_pattern_switch();
    pattern_sel = 2'd1;
    frame_pulse();
    for (int i = 1; i <= 8; i++) adv_pulse();
    pattern_sel = 2'd2;
    exp_q.push_back(4'h9);
    adv_pulse();
    exp = exp_q.pop_front();
    checks++;
    if (frame_pixel_out !== exp) begin
      errors++;
      $display("FAIL switch_midframe: got %h expected %h", frame_pixel_out, exp);
    end
    exp_q.push_back(4'h0);
    frame_pulse();
    exp = exp_q.pop_front();
    checks++;
    if (frame_pixel_out !== exp) begin
      errors++;
      $display("FAIL switch_checker_x0: got %h expected %h", frame_pixel_out, exp);
    end
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back((i >= 8) ? 4'hF : 4'h0);
      adv_pulse();
      exp = exp_q.pop_front();
      checks++;
      if (frame_pixel_out !== exp) begin
        errors++;
        $display("FAIL switch_checker_x%0d: got %h expected %h", i, frame_pixel_out, exp);
      end
    end
  endtask

  task automatic test_solid();
    pattern_sel = 2'd0;
    solid_level = 4'h9;
    exp_q.push_back(4'h9);
    frame_pulse();
    solid_level = 4'h3;
    exp_q.push_back(4'h9);
    exp = exp_q.pop_front();
    checks++;
    if (frame_pixel_out !== exp) begin
      errors++;
      $display("FAIL solid_start: got %h expected %h", frame_pixel_out, exp);
    end
    adv_pulse();
    exp = exp_q.pop_front();
    checks++;
    if (frame_pixel_out !== exp) begin
      errors++;
      $display("FAIL solid_midframe_level: got %h expected %h", frame_pixel_out, exp);
    end
  endtask

`ifdef FRAME_PIXEL_SOURCE_LINEBUF_EN
  task automatic test_pattern3();
    @(negedge clk) wr_ptr_clr = 1'b1;
    @(negedge clk) begin
      wr_ptr_clr = 1'b0;
      wr_en      = 1'b1;
      wr_data    = 4'hA;
    end
    @(negedge clk) wr_data = 4'hB;
    @(negedge clk) wr_en = 1'b0;
    pattern_sel = 2'd3;
    exp_q.push_back(4'hA);
    frame_pulse();
    exp = exp_q.pop_front();
    checks++;
    if (frame_pixel_out !== exp) begin
      errors++;
      $display("FAIL lb_entry0: got %h expected %h", frame_pixel_out, exp);
    end
    exp_q.push_back(4'hB);
    adv_pulse();
    exp = exp_q.pop_front();
    checks++;
    if (frame_pixel_out !== exp) begin
      errors++;
      $display("FAIL lb_entry1: got %h expected %h", frame_pixel_out, exp);
    end
    // Clear and write together: pointer clears, entry 0 keeps 0xA.
    @(negedge clk) begin
      wr_ptr_clr = 1'b1;
      wr_en      = 1'b1;
      wr_data    = 4'h7;
    end
    @(negedge clk) begin
      wr_ptr_clr = 1'b0;
      wr_en      = 1'b0;
    end
    exp_q.push_back(4'hA);
    frame_pulse();
    exp = exp_q.pop_front();
    checks++;
    if (frame_pixel_out !== exp) begin
      errors++;
      $display("FAIL lb_clr_priority: got %h expected %h", frame_pixel_out, exp);
    end
    for (int k = 0; k < 17; k++) begin
      @(negedge clk) begin
        wr_en   = 1'b1;
        wr_data = (k == 16) ? 4'hE : 4'(k);
      end
    end
    @(negedge clk) wr_en = 1'b0;
    exp_q.push_back(4'hE);
    frame_pulse();
    exp = exp_q.pop_front();
    checks++;
    if (frame_pixel_out !== exp) begin
      errors++;
      $display("FAIL lb_wrap_entry0: got %h expected %h", frame_pixel_out, exp);
    end
    exp_q.push_back(4'h1);
    adv_pulse();
    exp = exp_q.pop_front();
    checks++;
    if (frame_pixel_out !== exp) begin
      errors++;
      $display("FAIL lb_wrap_entry1: got %h expected %h", frame_pixel_out, exp);
    end
  endtask
`else
  task automatic test_pattern3();
    // Write port must be inert; pattern 3 shows the line number.
    @(negedge clk) begin
      wr_en   = 1'b1;
      wr_data = 4'hA;
    end
    @(negedge clk) wr_en = 1'b0;
    pattern_sel = 2'd3;
    exp_q.push_back(4'h0);
    frame_pulse();
    exp = exp_q.pop_front();
    checks++;
    if (frame_pixel_out !== exp) begin
      errors++;
      $display("FAIL y_pattern_start: got %h expected %h", frame_pixel_out, exp);
    end
    for (int i = 1; i <= 161; i++) begin
      exp_q.push_back((i >= 160) ? 4'h1 : 4'h0);
      adv_pulse();
      exp = exp_q.pop_front();
      checks++;
      if (frame_pixel_out !== exp) begin
        errors++;
        $display("FAIL y_pattern_adv%0d: got %h expected %h", i, frame_pixel_out, exp);
      end
    end
  endtask
`endif

  task automatic test_frame_wrap();
    logic [3:0] ramp [8];
    ramp = '{4'h1, 4'h2, 4'h3, 4'h0, 4'h1, 4'h2, 4'h3, 4'h5};
    s_pattern_sel = 2'd1;
    exp_q.push_back(4'h0);
    s_frame_pulse();
    exp = exp_q.pop_front();
    checks++;
    if (s_frame_pixel_out !== exp) begin
      errors++;
      $display("FAIL wrap_start: got %h expected %h", s_frame_pixel_out, exp);
    end
    // New selection must only take effect on the wrap.
    s_pattern_sel = 2'd0;
    s_solid_level = 4'h5;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(ramp[i]);
      s_adv_pulse();
      exp = exp_q.pop_front();
      checks++;
      if (s_frame_pixel_out !== exp) begin
        errors++;
        $display("FAIL wrap_adv%0d: got %h expected %h", i + 1, s_frame_pixel_out, exp);
      end
    end
    checks++;
    if (s_frame_count !== 8'd1) begin
      errors++;
      $display("FAIL wrap_count: got %0d expected %0d", s_frame_count, 1);
    end
  endtask

  task automatic test_rst_midframe();
    s_pattern_sel = 2'd1;
    s_frame_pulse();
    s_adv_pulse();
    @(negedge clk) begin
      rst                   = 1'b1;
      s_frame_next_pixel_in = 1'b1;
    end
    @(negedge clk) begin
      rst                   = 1'b0;
      s_frame_next_pixel_in = 1'b0;
    end
    checks++;
    if (s_frame_pixel_out !== 4'h0) begin
      errors++;
      $display("FAIL rst_mid_pixel: got %h expected %h", s_frame_pixel_out, 4'h0);
    end
    checks++;
    if (s_frame_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_count: got %0d expected %0d", s_frame_count, 0);
    end
    // Active pattern reset to solid 0, so an advance still shows 0.
    s_adv_pulse();
    checks++;
    if (s_frame_pixel_out !== 4'h0) begin
      errors++;
      $display("FAIL rst_mid_pattern: got %h expected %h", s_frame_pixel_out, 4'h0);
    end
  endtask

  initial begin
    rst                   = 1'b1;
    frame_reset_in        = 1'b0;
    frame_next_pixel_in   = 1'b0;
    pattern_sel           = 2'd0;
    solid_level           = 4'h0;
    wr_en                 = 1'b0;
    wr_data               = 4'h0;
    wr_ptr_clr            = 1'b0;
    s_frame_reset_in      = 1'b0;
    s_frame_next_pixel_in = 1'b0;
    s_pattern_sel         = 2'd0;
    s_solid_level         = 4'h0;

    test_reset();
    test_ramp();
    test_level_hold();
    test_reset_priority();
    test_pattern_switch();
    test_solid();
    test_pattern3();
    test_frame_wrap();
    test_rst_midframe();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_pixel_source.md
FRAME_PIXEL_SOURCE -- requirements
Module: frame_pixel_source

Interface
REQ-001 SHALL have parameter H_PIXELS, default 160, meaning pixels per line (2..1024).
REQ-002 SHALL have parameter V_LINES, default 120, meaning lines per frame (2..1024).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port frame_reset_in, input, 1, frame-restart request from the VGA reader.
REQ-006 SHALL have port frame_next_pixel_in, input, 1, advance request from the VGA reader; level, may stay high for several cycles.
REQ-007 SHALL have port pattern_sel, input, 2, pattern select: 0 solid, 1 horizontal ramp, 2 checkerboard, 3 line buffer.
REQ-008 SHALL have port solid_level, input, 4, gray level for pattern 0.
REQ-009 SHALL have port wr_en, input, 1, line-buffer write strobe, one write per cycle high.
REQ-010 SHALL have port wr_data, input, 4, line-buffer write data.
REQ-011 SHALL have port wr_ptr_clr, input, 1, returns the line-buffer write pointer to 0.
REQ-012 SHALL have port frame_pixel_out, output, 4, current gray pixel presented to the reader.
REQ-013 SHALL have port frame_count, output, 8, completed-frame counter.

Function
REQ-014 SHALL hold registered counters x (0..H_PIXELS-1) and y (0..V_LINES-1).
REQ-015 SHALL register frame_next_pixel_in each cycle; an advance event is a cycle with input 1 and registered previous value 0.
REQ-016 SHALL, on an advance event, set x to x+1; at x=H_PIXELS-1 it sets x to 0 and y to y+1.
REQ-017 SHALL, on an advance event at x=H_PIXELS-1 and y=V_LINES-1, set x and y to 0 and increment frame_count, modulo 256.
REQ-018 SHALL, when frame_reset_in=1, set x and y to 0 and leave frame_count unchanged.
REQ-019 SHALL give frame_reset_in priority over a simultaneous advance event; that advance is discarded.
REQ-020 SHALL latch pattern_sel and solid_level into an active-pattern register only at frame start: on frame_reset_in=1, or on a y wrap to 0 per REQ-017; mid-frame changes have no effect.
REQ-021 SHALL compute frame_pixel_out as a registered function of the post-update x, y and active pattern.
REQ-022 SHALL make that output valid one clock after the cycle in which the update (advance or reset) is sampled.
REQ-023 SHALL produce these pixel values:
- pattern 0: latched solid_level.
- pattern 1: x[3:0].
- pattern 2: 4'hF when x[3] XOR y[3] = 1, otherwise 4'h0.
- pattern 3: linebuf[x[3:0]].
REQ-024 SHALL keep a 16x4 line buffer; on wr_en=1 it writes wr_data at the write pointer and increments the pointer, wrapping 15 to 0.
REQ-025 SHALL give wr_ptr_clr priority over wr_en in the same cycle: the pointer becomes 0 and no write occurs.
REQ-026 SHALL perform line-buffer writes independently of pixel reads; a same-cycle write and read of one entry returns the old data.
REQ-027 SHALL hold x, y and frame_pixel_out unchanged while no advance or reset event occurs.

Reset
REQ-028 SHALL, on rst=1, clear x, y, frame_count, the previous-advance register, the write pointer and frame_pixel_out to 0, and set the active pattern to 0 with solid level 0.
REQ-029 SHALL not clear line-buffer contents on reset.
REQ-030 SHALL give rst priority over all other inputs, including an operation in progress mid-frame.

Configuration
REQ-031 SHALL include the line buffer and write port only when macro FRAME_PIXEL_SOURCE_LINEBUF_EN is defined.
REQ-032 SHALL, without that macro, omit line-buffer storage, ignore wr_en, wr_data and wr_ptr_clr, and make pattern 3 output y[3:0].

Verification
REQ-033 SHALL cover: rst, pattern_sel=1, frame_reset pulse, then 3 advance pulses of 1 cycle each -> frame_pixel_out 0,1,2,3, each 1 cycle after its pulse.
REQ-034 SHALL cover: frame_next_pixel_in held high 5 cycles -> exactly one advance, x=1.
REQ-035 SHALL cover: H_PIXELS=4, V_LINES=2, 8 advances -> x=0, y=0, frame_count=1, active pattern re-latched.
REQ-036 SHALL cover: frame_reset_in and an advance edge in the same cycle at x=5 -> x=0, y=0, frame_count unchanged.
REQ-037 SHALL cover, with macro defined: wr_ptr_clr, then writes 0xA, 0xB, pattern 3 selected and frame reset -> pixels 0xA, 0xB at x=0,1; 17 writes -> entry 0 overwritten by the 17th.
REQ-038 SHALL cover: pattern_sel changed from 1 to 2 mid-frame -> output stays a ramp until the next frame start, then checkerboard (x=8, y=0 gives 0xF).
